// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_pkg
// Purpose : Shared types and constants for the pipeline stall/flush sequencer.
//           pc_state_t     - multiply occupancy FSM state
//           pipe_ctl_t     - bundle of per-pipe-register we/flush controls
//           CTL_*          - canned control bundles for each pipeline mode
// Revision: 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int MUL_LATENCY_MAX = 8;

    typedef enum logic {
        PC_RUN = 1'b0,
        PC_MUL = 1'b1
    } pc_state_t;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_flush;
        logic ex_mem_we;
        logic ex_mem_flush;
        logic mem_wb_we;
    } pipe_ctl_t;

    // Everything held, every flushable register loads a bubble.
    localparam pipe_ctl_t CTL_RESET   = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1,
                                          id_ex_we: 1'b0, id_ex_flush: 1'b1, ex_mem_we: 1'b0,
                                          ex_mem_flush: 1'b1, mem_wb_we: 1'b0};
    // Free-running pipeline.
    localparam pipe_ctl_t CTL_DEFAULT = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                          id_ex_we: 1'b1, id_ex_flush: 1'b0, ex_mem_we: 1'b1,
                                          ex_mem_flush: 1'b0, mem_wb_we: 1'b1};
    // Front end and EX frozen; older work drains and a bubble enters MEM.
    localparam pipe_ctl_t CTL_MUL     = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                          id_ex_we: 1'b0, id_ex_flush: 1'b0, ex_mem_we: 1'b1,
                                          ex_mem_flush: 1'b1, mem_wb_we: 1'b1};

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_if
// Purpose : Hazard inputs and pipe-register controls between the pipeline
//           datapath and the stall/flush sequencer.
//   master : sequencer side (consumes hazards, drives controls and counters)
//   slave  : datapath side  (drives hazards, consumes controls)
// Revision: 1.0  initial release
// ============================================================================
interface pipe_ctrl_if #(
    parameter int PERF_W = 32
);
    logic              ld_hazard;
    logic              ex_mul_valid;
    logic              ex_redirect;
    logic              pc_we;
    logic              if_id_we;
    logic              if_id_flush;
    logic              id_ex_we;
    logic              id_ex_flush;
    logic              ex_mem_we;
    logic              ex_mem_flush;
    logic              mem_wb_we;
    logic              mul_busy;
    logic              mul_done;
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] flush_count;

    modport master (
        input  ld_hazard, ex_mul_valid, ex_redirect,
        output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, ex_mem_flush, mem_wb_we, mul_busy, mul_done,
               stall_cycles, flush_count
    );

    modport slave (
        output ld_hazard, ex_mul_valid, ex_redirect,
        input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, ex_mem_flush, mem_wb_we, mul_busy, mul_done,
               stall_cycles, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : W-bit up counter that sticks at all-ones instead of wrapping.
//   clock  in  1  system clock
//   reset  in  1  synchronous, active-high; clears count
//   inc    in  1  count this cycle
//   count  out W  current value
// Revision: 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  wire logic         clock,
    input  wire logic         reset,
    input  wire logic         inc,
    output logic [W-1:0]      count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl
// Purpose : Stall/flush sequencer for the 5-stage pipeline. Merges load-use
//           hazards, multi-cycle multiply occupancy of EX and EX redirects
//           into per-pipe-register we/flush controls (combinational from the
//           registered FSM state and current inputs). Also keeps saturating
//           counts of stalled cycles and redirect flushes.
//   clock  in  1  system clock
//   reset  in  1  synchronous, active-high
//   bus    pipe_ctrl_if.master  hazards in, controls/counters out
// Revision: 1.0  initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 3,
    parameter int PERF_W      = 32
) (
    input  wire logic   clock,
    input  wire logic   reset,
    pipe_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] C_MUL_LAST = CNT_W'(MUL_LATENCY - 1);

    pc_state_t        r_state;
    logic [CNT_W-1:0] r_mul_cnt;

    pipe_ctl_t   w_ctl;
    logic        w_mul_busy;
    logic        w_mul_done;
    logic        w_redirect;
    logic        w_mul_last;
    logic [PERF_W-1:0] w_stall_cycles;
    logic [PERF_W-1:0] w_flush_count;

    assign w_mul_last = (r_state == PC_MUL) && (r_mul_cnt == C_MUL_LAST);

    // Priority: reset > multiply > redirect > load-use > default.
    // Once a multiply owns EX, redirect/load-use are ignored until it retires;
    // the frozen ID instruction is simply re-evaluated afterwards.
    always_comb begin
        w_ctl      = CTL_DEFAULT;
        w_mul_busy = 1'b0;
        w_mul_done = 1'b0;
        w_redirect = 1'b0;
        if (reset) begin
            w_ctl = CTL_RESET;
        end else if (r_state == PC_MUL) begin
            if (w_mul_last) begin
                w_mul_done = 1'b1;
            end else begin
                w_ctl      = CTL_MUL;
                w_mul_busy = 1'b1;
            end
        end else if (bus.ex_mul_valid) begin
            w_ctl      = CTL_MUL;
            w_mul_busy = 1'b1;
        end else if (bus.ex_redirect) begin
            // Younger instructions in IF and ID are squashed; a concurrent
            // load-use hazard belongs to a squashed instruction.
            w_ctl.if_id_flush = 1'b1;
            w_ctl.id_ex_flush = 1'b1;
            w_redirect        = 1'b1;
        end else if (bus.ld_hazard) begin
            w_ctl.pc_we       = 1'b0;
            w_ctl.if_id_we    = 1'b0;
            w_ctl.id_ex_flush = 1'b1;
        end
    end

    // Multiply occupancy FSM: entry cycle is count 0 (in RUN), MUL counts
    // 1..MUL_LATENCY-1, and the last count is the retire cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= PC_RUN;
            r_mul_cnt <= '0;
        end else if (r_state == PC_RUN) begin
            if (bus.ex_mul_valid) begin
                r_state   <= PC_MUL;
                r_mul_cnt <= CNT_W'(1);
            end
        end else begin
            if (w_mul_last) begin
                r_state   <= PC_RUN;
                r_mul_cnt <= '0;
            end else begin
                r_mul_cnt <= r_mul_cnt + CNT_W'(1);
            end
        end
    end

    // pc_we is forced low during reset, but the counter clears then anyway.
    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (~w_ctl.pc_we),
        .count (w_stall_cycles)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_redirect),
        .count (w_flush_count)
    );

    assign bus.pc_we        = w_ctl.pc_we;
    assign bus.if_id_we     = w_ctl.if_id_we;
    assign bus.if_id_flush  = w_ctl.if_id_flush;
    assign bus.id_ex_we     = w_ctl.id_ex_we;
    assign bus.id_ex_flush  = w_ctl.id_ex_flush;
    assign bus.ex_mem_we    = w_ctl.ex_mem_we;
    assign bus.ex_mem_flush = w_ctl.ex_mem_flush;
    assign bus.mem_wb_we    = w_ctl.mem_wb_we;
    assign bus.mul_busy     = w_mul_busy;
    assign bus.mul_done     = w_mul_done;
    assign bus.stall_cycles = w_stall_cycles;
    assign bus.flush_count  = w_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_ctrl
// Purpose : Directed self-checking bench for pipe_ctrl. Two instances share
//           the clock and reset: a 32-bit-counter instance for the control
//           sequences and a 4-bit-counter instance for saturation.
// Revision: 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pipe_ctrl_if #(.PERF_W(32)) bus ();
    pipe_ctrl_if #(.PERF_W(4))  sbus ();

    pipe_ctrl #(.MUL_LATENCY(4), .CNT_W(3), .PERF_W(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    pipe_ctrl #(.MUL_LATENCY(4), .CNT_W(3), .PERF_W(4)) dut_s (
        .clock (clk),
        .reset (rst),
        .bus   (sbus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One EX instruction: a redirect and a multiply can never coexist.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.ex_redirect && bus.ex_mul_valid))
                else $error("illegal redirect with multiply");
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Packs the main instance controls: {pc,ifid_we,ifid_fl,idex_we,idex_fl,exmem_fl,memwb_we,busy,done}
    function automatic logic [8:0] ctl_vec();
        return {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_we, bus.id_ex_flush,
                bus.ex_mem_flush, bus.mem_wb_we, bus.mul_busy, bus.mul_done};
    endfunction

    localparam logic [8:0] V_RESET = 9'b0_0_1_0_1_1_0_0_0;
    localparam logic [8:0] V_IDLE  = 9'b1_1_0_1_0_0_1_0_0;
    localparam logic [8:0] V_LOAD  = 9'b0_0_0_1_1_0_1_0_0;
    localparam logic [8:0] V_MUL   = 9'b0_0_0_0_0_1_1_1_0;
    localparam logic [8:0] V_DONE  = 9'b1_1_0_1_0_0_1_0_1;
    localparam logic [8:0] V_REDIR = 9'b1_1_1_1_1_0_1_0_0;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.ld_hazard = 1'b0;  bus.ex_mul_valid = 1'b0;  bus.ex_redirect = 1'b0;
        sbus.ld_hazard = 1'b0; sbus.ex_mul_valid = 1'b0; sbus.ex_redirect = 1'b0;

        // 1. reset, then idle
        @(negedge clk);
        chk("reset_ctl", 32'(ctl_vec()), 32'(V_RESET));
        chk("reset_exmem_we", 32'(bus.ex_mem_we), 32'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("idle_ctl%0d", i), 32'(ctl_vec()), 32'(V_IDLE));
            next_cycle();
        end
        chk("idle_stall", bus.stall_cycles, 32'd0);
        chk("idle_flush", bus.flush_count, 32'd0);

        // 2. single load-use bubble
        bus.ld_hazard = 1'b1;
        @(negedge clk);
        chk("load_ctl", 32'(ctl_vec()), 32'(V_LOAD));
        next_cycle();
        bus.ld_hazard = 1'b0;
        @(negedge clk);
        chk("load_after_ctl", 32'(ctl_vec()), 32'(V_IDLE));
        chk("load_stall", bus.stall_cycles, 32'd1);
        next_cycle();

        // 3. four-cycle multiply; hazards during it are ignored
        bus.ex_mul_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.ld_hazard = (k == 1);
            @(negedge clk);
            chk($sformatf("mul_ctl%0d", k), 32'(ctl_vec()), 32'((k < 3) ? V_MUL : V_DONE));
            next_cycle();
        end
        bus.ex_mul_valid = 1'b0;
        bus.ld_hazard    = 1'b0;
        @(negedge clk);
        chk("mul_after_ctl", 32'(ctl_vec()), 32'(V_IDLE));
        chk("mul_stall", bus.stall_cycles, 32'd4);
        next_cycle();

        // 4. redirect beats a simultaneous load-use hazard
        bus.ex_redirect = 1'b1;
        bus.ld_hazard   = 1'b1;
        @(negedge clk);
        chk("redir_ctl", 32'(ctl_vec()), 32'(V_REDIR));
        next_cycle();
        bus.ex_redirect = 1'b0;
        bus.ld_hazard   = 1'b0;
        @(negedge clk);
        chk("redir_flush_cnt", bus.flush_count, 32'd1);
        chk("redir_stall", bus.stall_cycles, 32'd4);
        next_cycle();

        // 5. reset while mul_cnt==2 aborts the multiply
        bus.ex_mul_valid = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_reset_ctl", 32'(ctl_vec()), 32'(V_RESET));
        next_cycle();
        rst = 1'b0;
        bus.ex_mul_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort_ctl%0d", i), 32'(ctl_vec()), 32'(V_IDLE));
            next_cycle();
        end
        chk("abort_stall", bus.stall_cycles, 32'd0);
        chk("abort_flush", bus.flush_count, 32'd0);
        // A fresh multiply must take the full latency from count 0.
        bus.ex_mul_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("remul_ctl%0d", k), 32'(ctl_vec()), 32'((k < 3) ? V_MUL : V_DONE));
            next_cycle();
        end
        bus.ex_mul_valid = 1'b0;
        chk("remul_stall", bus.stall_cycles, 32'd3);

        // 6. 4-bit stall counter saturates at 15
        chk("sat_start", 32'(sbus.stall_cycles), 32'd0);
        sbus.ld_hazard = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            if (i == 14) chk("sat_14", 32'(sbus.stall_cycles), 32'd14);
            if (i == 15) chk("sat_15", 32'(sbus.stall_cycles), 32'd15);
        end
        chk("sat_hold", 32'(sbus.stall_cycles), 32'd15);
        chk("sat_flush", 32'(sbus.flush_count), 32'd0);
        sbus.ld_hazard = 1'b0;
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
